fir_mac_ctrl: RTL and testbench
===============================

# fir_mac_ctrl

Sequencer for the FIR filter's MAC datapath and coefficient single-port SRAM. On each new input sample it walks all taps: it issues SRAM reads, then drives the MAC's multiply and add/accumulate enables and tap indices in a fixed 3-stage pipeline, and flags the finished output. Between samples it can own the SRAM port in an update mode so the host can rewrite coefficients. It sits between the sample-rate strobe / host register interface and the `MAC` + SpSram pair.

## Interface
- `NUM_TAP`, default 10: taps per output sample.
- `COEFF_W`, default 16: coefficient width.
- `ADDR_W`, default 4: SRAM address / tap index width.

Ports:
- `iClk12M`  in  1  system clock, 12 MHz.
- `iRsn`  in  1  reset, synchronous, active-low.
- `iEnSample`  in  1  single-cycle pulse: a new sample has been shifted into the delay chain.
- `iCoeffUpdate`  in  1  level: request coefficient update mode.
- `iCoeffWrEn`  in  1  host write strobe, honoured only in UPDATE.
- `iCoeffWrAddr`  in  ADDR_W  host write address.
- `iCoeffWrData`  in  COEFF_W  host write data.
- `oCsn`  out  1  SRAM chip select, active-low.
- `oWrn`  out  1  SRAM write enable, active-low (1 = read).
- `oAddr`  out  ADDR_W  SRAM address.
- `oWrDt`  out  COEFF_W  SRAM write data.
- `oAccClr`  out  1  clears MAC accumulators at the start of a sample.
- `oEnMul`  out  1  MAC multiply enable.
- `oMulIdx`  out  ADDR_W  tap index for the multiply stage.
- `oEnAddAcc`  out  1  MAC add/accumulate enable.
- `oAccIdx`  out  ADDR_W  tap index for the accumulate stage.
- `oOutValid`  out  1  one-cycle pulse: MAC output is final.
- `oBusy`  out  1  high in every state except IDLE.
- `oSampleDrop`  out  1  one-cycle pulse: `iEnSample` was ignored.

## Operation
- States: IDLE, RUN, DRAIN, DONE, UPDATE.
- In IDLE:
  - `iEnSample` -> RUN. Sample has priority over `iCoeffUpdate` when both are high.
  - Otherwise, `iCoeffUpdate` high -> UPDATE.
- RUN:
  - Tap counter runs 0..NUM_TAP-1.
  - Each cycle: `oCsn`=0, `oWrn`=1, `oAddr`=counter.
  - When the counter reaches NUM_TAP-1 -> DRAIN. The counter never holds NUM_TAP; it wraps to 0.
- Read valid pipeline:
  - Stage 1 = SRAM data valid -> `oEnMul`/`oMulIdx`.
  - Stage 2 -> `oEnAddAcc`/`oAccIdx`.
- DRAIN lasts exactly 2 cycles, until the stage-2 pipeline empties, then -> DONE.
- DONE: `oOutValid`=1 for one cycle, then -> IDLE, or -> UPDATE if `iCoeffUpdate` is high.
- UPDATE:
  - A write with `iCoeffWrEn`=1 and `iCoeffWrAddr` < NUM_TAP drives `oCsn`=0, `oWrn`=0, and registered `oAddr`/`oWrDt` on the next cycle.
  - Writes with out-of-range addresses are ignored: `oCsn` stays 1.
  - `iCoeffUpdate` low -> IDLE. A write issued on the same cycle is still performed.
- `iEnSample` outside IDLE, including DONE and UPDATE: ignored and `oSampleDrop` pulses. The in-flight computation is unaffected.
- `iCoeffUpdate` rising during RUN/DRAIN: the current sample completes first.
- `iCoeffWrEn` outside UPDATE is ignored.

## Timing
- All outputs are registered.
- For `iEnSample` high at edge T (in IDLE):
  - `oAccClr`=1 and the address-0 read during cycle T+1.
  - Address k is read at T+1+k.
  - `oEnMul` with `oMulIdx`=k at T+2+k.
  - `oEnAddAcc` with `oAccIdx`=k at T+3+k.
  - Last accumulate at T+NUM_TAP+2.
  - `oOutValid` at T+NUM_TAP+3 (T+13 for 10 taps). IDLE again at T+NUM_TAP+4.
- Minimum sample spacing: NUM_TAP+4 cycles (14); the nominal spacing is 250.
- UPDATE write latency: 1 cycle from `iCoeffWrEn` to SRAM strobe. Back-to-back writes are accepted every cycle.
- Reset values:
  - `oCsn`=1, `oWrn`=1, `oAddr`=0, `oWrDt`=0.
  - `oAccClr`, `oEnMul`, `oEnAddAcc`, `oOutValid`, `oBusy`, `oSampleDrop` all 0.
  - `oMulIdx`=`oAccIdx`=0.
  - State IDLE, pipeline valids cleared.
- Reset asserted mid-RUN/UPDATE: all of the above take effect at the next edge. There is no partial `oOutValid` and no pending SRAM write.

## Structure
- Shared package `fir_pkg`:
  - `NUM_TAP`, `COEFF_W`, `ADDR_W` constants.
  - State enum `fir_ctrl_state_t`.
- One sub-module, `fir_tap_pipe`: a 2-stage valid+index shift register producing the mul/acc enables and indices. The FSM, tap counter and SRAM mux stay in the top module.

## Test plan
- Reset, then a single `iEnSample` at T:
  - Reads at addresses 0..9 over T+1..T+10.
  - `oEnMul` idx 0..9 at T+2..T+11.
  - `oEnAddAcc` idx 0..9 at T+3..T+12.
  - `oOutValid` exactly at T+13.
  - `oBusy` high T+1..T+13.
- Second `iEnSample` at T+5 -> `oSampleDrop` pulse at T+6; first sample timing unchanged; no extra reads.
- `iCoeffUpdate`=1 in IDLE, writes of addresses 0..9 with data 16'h0100+addr, then address 12:
  - Ten SRAM writes with `oWrn`=0, one cycle after each strobe.
  - Address 12 gives no strobe.
  - A subsequent sample reads the new values.
- `iCoeffUpdate` raised at T+4 during RUN -> sample completes with `oOutValid` at T+13, UPDATE entered at T+14.
- `iRsn` low at T+6 for one cycle -> all outputs at reset values from T+7, no `oOutValid`, next `iEnSample` runs a clean 13-cycle sequence.
- `iEnSample` and `iCoeffUpdate` high together in IDLE -> RUN first, UPDATE after DONE.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants and state type for the FIR MAC sequencer.
package fir_pkg;

    localparam int NUM_TAP   = 10;
    localparam int COEFF_W   = 16;
    localparam int ADDR_W    = 4;
    // Cycles spent after the last read so the tap pipeline can empty.
    localparam int DRAIN_CYC = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE,
        ST_UPDATE
    } fir_ctrl_state_t;

endpackage

// File: rtl/fir_tap_pipe.sv
// Two-stage valid/index shift register that turns an SRAM read strobe
// into the MAC multiply enable and, one cycle later, the accumulate enable.
module fir_tap_pipe #(
    parameter int ADDR_W = fir_pkg::ADDR_W
) (
    input  logic              clk_i,
    input  logic              rsn_i,
    input  logic              vld_i,
    input  logic [ADDR_W-1:0] idx_i,
    output logic              mulEn_o,
    output logic [ADDR_W-1:0] mulIdx_o,
    output logic              accEn_o,
    output logic [ADDR_W-1:0] accIdx_o
);

    logic              mulEn_q;
    logic [ADDR_W-1:0] mulIdx_q;
    logic              accEn_q;
    logic [ADDR_W-1:0] accIdx_q;

    // Shift the read-valid and its tap index down the mul -> acc stages.
    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            mulEn_q  <= 1'b0;
            mulIdx_q <= '0;
            accEn_q  <= 1'b0;
            accIdx_q <= '0;
        end else begin
            mulEn_q <= vld_i;
            accEn_q <= mulEn_q;
            if (vld_i) begin
                mulIdx_q <= idx_i;
            end
            if (mulEn_q) begin
                accIdx_q <= mulIdx_q;
            end
        end
    end

    assign mulEn_o  = mulEn_q;
    assign mulIdx_o = mulIdx_q;
    assign accEn_o  = accEn_q;
    assign accIdx_o = accIdx_q;

endmodule

// File: rtl/fir_mac_ctrl.sv
// Sequencer for the FIR MAC datapath and its coefficient single-port SRAM.
// Walks all taps per input sample and lets the host rewrite coefficients
// while idle between samples.
module fir_mac_ctrl #(
    parameter int NUM_TAP = fir_pkg::NUM_TAP,
    parameter int COEFF_W = fir_pkg::COEFF_W,
    parameter int ADDR_W  = fir_pkg::ADDR_W
) (
    input  logic               iClk12M,
    input  logic               iRsn,
    input  logic               iEnSample,
    input  logic               iCoeffUpdate,
    input  logic               iCoeffWrEn,
    input  logic [ADDR_W-1:0]  iCoeffWrAddr,
    input  logic [COEFF_W-1:0] iCoeffWrData,
    output logic               oCsn,
    output logic               oWrn,
    output logic [ADDR_W-1:0]  oAddr,
    output logic [COEFF_W-1:0] oWrDt,
    output logic               oAccClr,
    output logic               oEnMul,
    output logic [ADDR_W-1:0]  oMulIdx,
    output logic               oEnAddAcc,
    output logic [ADDR_W-1:0]  oAccIdx,
    output logic               oOutValid,
    output logic               oBusy,
    output logic               oSampleDrop
);

    import fir_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_TAP   = ADDR_W'(NUM_TAP - 1);
    localparam logic [ADDR_W-1:0] DRAIN_LAST = ADDR_W'(DRAIN_CYC - 1);
    localparam logic [ADDR_W:0]   TAP_LIMIT  = (ADDR_W+1)'(NUM_TAP);

    fir_ctrl_state_t    state_q, state_d;
    logic [ADDR_W-1:0]  cnt_q, cnt_d;
    logic               csn_q, csn_d;
    logic               wrn_q, wrn_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [COEFF_W-1:0] wrDt_q, wrDt_d;
    logic               accClr_q, accClr_d;
    logic               outValid_q, outValid_d;
    logic               busy_q, busy_d;
    logic               drop_q, drop_d;

    logic [ADDR_W-1:0]  cntInc;
    logic               wrInRange;
    logic               rdVld;

    assign cntInc    = cnt_q + 1'b1;
    assign wrInRange = ({1'b0, iCoeffWrAddr} < TAP_LIMIT);

    // State, counter and every output are registered together here.
    always_ff @(posedge iClk12M) begin
        if (!iRsn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            csn_q      <= 1'b1;
            wrn_q      <= 1'b1;
            addr_q     <= '0;
            wrDt_q     <= '0;
            accClr_q   <= 1'b0;
            outValid_q <= 1'b0;
            busy_q     <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            csn_q      <= csn_d;
            wrn_q      <= wrn_d;
            addr_q     <= addr_d;
            wrDt_q     <= wrDt_d;
            accClr_q   <= accClr_d;
            outValid_q <= outValid_d;
            busy_q     <= busy_d;
            drop_q     <= drop_d;
        end
    end

    // Next-state logic and the next value of each registered output.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        csn_d      = 1'b1;
        wrn_d      = 1'b1;
        addr_d     = addr_q;
        wrDt_d     = wrDt_q;
        accClr_d   = 1'b0;
        outValid_d = 1'b0;
        drop_d     = iEnSample && (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (iEnSample) begin
                    state_d  = ST_RUN;
                    cnt_d    = '0;
                    csn_d    = 1'b0;
                    addr_d   = '0;
                    accClr_d = 1'b1;
                end else if (iCoeffUpdate) begin
                    state_d = ST_UPDATE;
                end
            end
            ST_RUN: begin
                if (cnt_q == LAST_TAP) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d  = cntInc;
                    csn_d  = 1'b0;
                    addr_d = cntInc;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d    = ST_DONE;
                    cnt_d      = '0;
                    outValid_d = 1'b1;
                end else begin
                    cnt_d = cntInc;
                end
            end
            ST_DONE: begin
                state_d = iCoeffUpdate ? ST_UPDATE : ST_IDLE;
            end
            ST_UPDATE: begin
                if (iCoeffWrEn && wrInRange) begin
                    csn_d  = 1'b0;
                    wrn_d  = 1'b0;
                    addr_d = iCoeffWrAddr;
                    wrDt_d = iCoeffWrData;
                end
                if (!iCoeffUpdate) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign rdVld = !csn_q && wrn_q;

    fir_tap_pipe #(
        .ADDR_W (ADDR_W)
    ) uTapPipe (
        .clk_i    (iClk12M),
        .rsn_i    (iRsn),
        .vld_i    (rdVld),
        .idx_i    (addr_q),
        .mulEn_o  (oEnMul),
        .mulIdx_o (oMulIdx),
        .accEn_o  (oEnAddAcc),
        .accIdx_o (oAccIdx)
    );

    assign oCsn        = csn_q;
    assign oWrn        = wrn_q;
    assign oAddr       = addr_q;
    assign oWrDt       = wrDt_q;
    assign oAccClr     = accClr_q;
    assign oOutValid   = outValid_q;
    assign oBusy       = busy_q;
    assign oSampleDrop = drop_q;

endmodule

// File: tb/tb_fir_mac_ctrl.sv
// Directed testbench for fir_mac_ctrl with a behavioural coefficient SRAM.
module tb_fir_mac_ctrl;

    logic        iClk12M = 1'b0;
    logic        iRsn = 1'b0;
    logic        iEnSample = 1'b0;
    logic        iCoeffUpdate = 1'b0;
    logic        iCoeffWrEn = 1'b0;
    logic [3:0]  iCoeffWrAddr = 4'd0;
    logic [15:0] iCoeffWrData = 16'd0;
    logic        oCsn, oWrn;
    logic [3:0]  oAddr;
    logic [15:0] oWrDt;
    logic        oAccClr, oEnMul, oEnAddAcc, oOutValid, oBusy, oSampleDrop;
    logic [3:0]  oMulIdx, oAccIdx;

    int checks = 0;
    int failures = 0;

    logic [15:0] mem [0:15];
    logic [15:0] rdData;

    fir_mac_ctrl dut (
        .iClk12M      (iClk12M),
        .iRsn         (iRsn),
        .iEnSample    (iEnSample),
        .iCoeffUpdate (iCoeffUpdate),
        .iCoeffWrEn   (iCoeffWrEn),
        .iCoeffWrAddr (iCoeffWrAddr),
        .iCoeffWrData (iCoeffWrData),
        .oCsn         (oCsn),
        .oWrn         (oWrn),
        .oAddr        (oAddr),
        .oWrDt        (oWrDt),
        .oAccClr      (oAccClr),
        .oEnMul       (oEnMul),
        .oMulIdx      (oMulIdx),
        .oEnAddAcc    (oEnAddAcc),
        .oAccIdx      (oAccIdx),
        .oOutValid    (oOutValid),
        .oBusy        (oBusy),
        .oSampleDrop  (oSampleDrop)
    );

    // 12 MHz-ish clock; absolute period is irrelevant to the checks.
    always #5 iClk12M = ~iClk12M;

    // Single-port coefficient SRAM with registered read data.
    always @(posedge iClk12M) begin
        if (!oCsn) begin
            if (!oWrn) mem[oAddr] <= oWrDt;
            else       rdData     <= mem[oAddr];
        end
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge iClk12M);
        #1;
    endtask

    // Hold reset and confirm every output sits at its reset value.
    task automatic test_reset();
        iRsn = 1'b0;
        repeat (3) tick();
        checks++;
        if ({oCsn, oWrn, oAddr, oWrDt} !== {1'b1, 1'b1, 4'd0, 16'd0}) begin
            failures++;
            $display("[TB] FAIL reset_sram got csn=%b wrn=%b addr=%0d wrdt=%h want 1 1 0 0000", oCsn, oWrn, oAddr, oWrDt);
        end
        checks++;
        if ({oAccClr, oEnMul, oEnAddAcc, oOutValid, oBusy, oSampleDrop} !== 6'b000000) begin
            failures++;
            $display("[TB] FAIL reset_flags got %b want 000000", {oAccClr, oEnMul, oEnAddAcc, oOutValid, oBusy, oSampleDrop});
        end
        checks++;
        if ({oMulIdx, oAccIdx} !== 8'd0) begin
            failures++;
            $display("[TB] FAIL reset_idx got mul=%0d acc=%0d want 0 0", oMulIdx, oAccIdx);
        end
        iRsn = 1'b1;
        tick();
    endtask

    // One sample: check reads, mul, acc, clear/valid/busy on every cycle T+1..T+14.
    task automatic test_single_sample();
        logic expRd, expMul, expAcc;
        iEnSample = 1'b1;
        tick();
        iEnSample = 1'b0;
        for (int j = 1; j <= 14; j++) begin
            if (j > 1) tick();
            expRd  = (j >= 1) && (j <= 10);
            expMul = (j >= 2) && (j <= 11);
            expAcc = (j >= 3) && (j <= 12);
            checks++;
            if (oCsn !== !expRd || (expRd && (oWrn !== 1'b1 || oAddr !== 4'(j - 1)))) begin
                failures++;
                $display("[TB] FAIL single_read T+%0d got csn=%b wrn=%b addr=%0d want rd=%b addr=%0d", j, oCsn, oWrn, oAddr, expRd, j - 1);
            end
            checks++;
            if (oEnMul !== expMul || (expMul && oMulIdx !== 4'(j - 2))) begin
                failures++;
                $display("[TB] FAIL single_mul T+%0d got en=%b idx=%0d want en=%b idx=%0d", j, oEnMul, oMulIdx, expMul, j - 2);
            end
            checks++;
            if (oEnAddAcc !== expAcc || (expAcc && oAccIdx !== 4'(j - 3))) begin
                failures++;
                $display("[TB] FAIL single_acc T+%0d got en=%b idx=%0d want en=%b idx=%0d", j, oEnAddAcc, oAccIdx, expAcc, j - 3);
            end
            checks++;
            if ({oAccClr, oOutValid, oBusy} !== {(j == 1), (j == 13), (j <= 13)}) begin
                failures++;
                $display("[TB] FAIL single_flags T+%0d got clr/vld/busy=%b want %b", j, {oAccClr, oOutValid, oBusy}, {(j == 1), (j == 13), (j <= 13)});
            end
        end
    endtask

    // Second sample at T+5 is dropped; first sample is unaffected.
    task automatic test_sample_drop();
        int reads = 0;
        iEnSample = 1'b1;
        tick();
        for (int j = 1; j <= 14; j++) begin
            if (j > 1) tick();
            iEnSample = (j == 5);
            if (!oCsn && oWrn) reads++;
            checks++;
            if (oSampleDrop !== (j == 6)) begin
                failures++;
                $display("[TB] FAIL drop_pulse T+%0d got %b want %b", j, oSampleDrop, (j == 6));
            end
            checks++;
            if (oOutValid !== (j == 13)) begin
                failures++;
                $display("[TB] FAIL drop_outvalid T+%0d got %b want %b", j, oOutValid, (j == 13));
            end
        end
        checks++;
        if (reads != 10) begin
            failures++;
            $display("[TB] FAIL drop_reads got %0d want 10", reads);
        end
    endtask

    // Host rewrites coefficients, then a sample reads the new values.
    task automatic test_update();
        iCoeffWrEn = 1'b1;
        iCoeffWrAddr = 4'd2;
        iCoeffWrData = 16'hBEEF;
        tick();
        checks++;
        if (oCsn !== 1'b1) begin
            failures++;
            $display("[TB] FAIL wr_outside_update got csn=%b want 1", oCsn);
        end
        iCoeffWrEn = 1'b0;
        iCoeffUpdate = 1'b1;
        tick();
        checks++;
        if (oBusy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL upd_enter_busy got %b want 1", oBusy);
        end
        for (int a = 0; a < 10; a++) begin
            iCoeffWrEn = 1'b1;
            iCoeffWrAddr = 4'(a);
            iCoeffWrData = 16'h0100 + 16'(a);
            tick();
            checks++;
            if (oCsn !== 1'b0 || oWrn !== 1'b0 || oAddr !== 4'(a) || oWrDt !== 16'h0100 + 16'(a)) begin
                failures++;
                $display("[TB] FAIL upd_write a=%0d got csn=%b wrn=%b addr=%0d data=%h want 0 0 %0d %h", a, oCsn, oWrn, oAddr, oWrDt, a, 16'h0100 + 16'(a));
            end
        end
        iCoeffWrAddr = 4'd12;
        iCoeffWrData = 16'h0BAD;
        tick();
        checks++;
        if (oCsn !== 1'b1) begin
            failures++;
            $display("[TB] FAIL upd_out_of_range got csn=%b want 1", oCsn);
        end
        iCoeffWrEn = 1'b0;
        iCoeffUpdate = 1'b0;
        tick();
        checks++;
        if (oBusy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL upd_exit_busy got %b want 0", oBusy);
        end
        iEnSample = 1'b1;
        tick();
        iEnSample = 1'b0;
        for (int j = 1; j <= 14; j++) begin
            if (j > 1) tick();
            if (j >= 2 && j <= 11) begin
                checks++;
                if (rdData !== 16'h0100 + 16'(j - 2)) begin
                    failures++;
                    $display("[TB] FAIL upd_readback tap=%0d got %h want %h", j - 2, rdData, 16'h0100 + 16'(j - 2));
                end
            end
        end
    endtask

    // Update request mid-run: sample finishes, then UPDATE at T+14.
    task automatic test_update_during_run();
        iEnSample = 1'b1;
        tick();
        iEnSample = 1'b0;
        for (int j = 1; j <= 15; j++) begin
            if (j > 1) tick();
            if (j == 4) iCoeffUpdate = 1'b1;
            checks++;
            if (oOutValid !== (j == 13)) begin
                failures++;
                $display("[TB] FAIL udr_outvalid T+%0d got %b want %b", j, oOutValid, (j == 13));
            end
            if (j == 14) begin
                checks++;
                if (oBusy !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL udr_busy_T14 got %b want 1", oBusy);
                end
                iCoeffWrEn = 1'b1;
                iCoeffWrAddr = 4'd5;
                iCoeffWrData = 16'h0105;
            end
            if (j == 15) begin
                checks++;
                if (oCsn !== 1'b0 || oWrn !== 1'b0 || oAddr !== 4'd5) begin
                    failures++;
                    $display("[TB] FAIL udr_write got csn=%b wrn=%b addr=%0d want 0 0 5", oCsn, oWrn, oAddr);
                end
            end
        end
        iCoeffWrEn = 1'b0;
        iCoeffUpdate = 1'b0;
        tick();
        checks++;
        if (oBusy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL udr_exit_busy got %b want 0", oBusy);
        end
    endtask

    // Reset pulse at T+6 aborts the sample; the next sample runs cleanly.
    task automatic test_reset_mid_run();
        int reads = 0;
        iEnSample = 1'b1;
        tick();
        iEnSample = 1'b0;
        for (int j = 1; j <= 16; j++) begin
            if (j > 1) tick();
            if (j == 6) iRsn = 1'b0;
            if (j == 7) begin
                iRsn = 1'b1;
                checks++;
                if ({oCsn, oWrn, oAddr, oWrDt} !== {1'b1, 1'b1, 4'd0, 16'd0} ||
                    {oAccClr, oEnMul, oEnAddAcc, oOutValid, oBusy, oSampleDrop} !== 6'b000000 ||
                    {oMulIdx, oAccIdx} !== 8'd0) begin
                    failures++;
                    $display("[TB] FAIL rst_mid_values csn=%b wrn=%b addr=%0d wrdt=%h flags=%b idx=%0d/%0d want reset values",
                             oCsn, oWrn, oAddr, oWrDt, {oAccClr, oEnMul, oEnAddAcc, oOutValid, oBusy, oSampleDrop}, oMulIdx, oAccIdx);
                end
            end
            if (j >= 8) begin
                checks++;
                if (oOutValid !== 1'b0 || oCsn !== 1'b1 || oEnMul !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL rst_mid_quiet T+%0d got vld=%b csn=%b mul=%b want 0 1 0", j, oOutValid, oCsn, oEnMul);
                end
            end
        end
        iEnSample = 1'b1;
        tick();
        iEnSample = 1'b0;
        for (int j = 1; j <= 14; j++) begin
            if (j > 1) tick();
            if (!oCsn && oWrn) reads++;
            checks++;
            if ({oOutValid, oBusy} !== {(j == 13), (j <= 13)}) begin
                failures++;
                $display("[TB] FAIL rst_next_flags T+%0d got vld/busy=%b want %b", j, {oOutValid, oBusy}, {(j == 13), (j <= 13)});
            end
        end
        checks++;
        if (reads != 10) begin
            failures++;
            $display("[TB] FAIL rst_next_reads got %0d want 10", reads);
        end
    endtask

    // Sample and update together in IDLE: RUN first, UPDATE after DONE.
    task automatic test_sample_and_update();
        iEnSample = 1'b1;
        iCoeffUpdate = 1'b1;
        tick();
        iEnSample = 1'b0;
        checks++;
        if (oAccClr !== 1'b1 || oCsn !== 1'b0 || oWrn !== 1'b1 || oAddr !== 4'd0) begin
            failures++;
            $display("[TB] FAIL both_run_first got clr=%b csn=%b wrn=%b addr=%0d want 1 0 1 0", oAccClr, oCsn, oWrn, oAddr);
        end
        for (int j = 2; j <= 14; j++) begin
            tick();
            checks++;
            if (oOutValid !== (j == 13)) begin
                failures++;
                $display("[TB] FAIL both_outvalid T+%0d got %b want %b", j, oOutValid, (j == 13));
            end
        end
        checks++;
        if (oBusy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL both_update_busy got %b want 1", oBusy);
        end
        iCoeffWrEn = 1'b1;
        iCoeffWrAddr = 4'd9;
        iCoeffWrData = 16'h0109;
        tick();
        checks++;
        if (oCsn !== 1'b0 || oWrn !== 1'b0 || oAddr !== 4'd9 || oWrDt !== 16'h0109) begin
            failures++;
            $display("[TB] FAIL both_update_write got csn=%b wrn=%b addr=%0d data=%h want 0 0 9 0109", oCsn, oWrn, oAddr, oWrDt);
        end
        iCoeffWrEn = 1'b0;
        iCoeffUpdate = 1'b0;
        tick();
        checks++;
        if (oBusy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL both_exit_busy got %b want 0", oBusy);
        end
    endtask

    // Run the scenarios in order, then report.
    initial begin
        $display("[TB] starting fir_mac_ctrl bench");
        test_reset();
        test_single_sample();
        test_sample_drop();
        test_update();
        test_update_during_run();
        test_reset_mid_run();
        test_sample_and_update();
        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
